// File: rtl/dec_queue_pkg.sv
// Shared decode definitions: widths, micro-op codes and type classes.
// Op codes are dense 6-bit values; OP_NOP (0) is also the op of an illegal entry.
// Type classes select the issue path: branch, load, store or ALU.
package dec_queue_pkg;

  localparam int OP_W      = 6;
  localparam int REG_BIT   = 5;
  localparam int DAT_W     = 32;
  localparam int RAM_ADR_W = 32;

  localparam logic [1:0] TP_BR  = 2'd0;
  localparam logic [1:0] TP_LD  = 2'd1;
  localparam logic [1:0] TP_ST  = 2'd2;
  localparam logic [1:0] TP_ALU = 2'd3;

  localparam logic [OP_W-1:0] OP_NOP   = 6'd0;
  localparam logic [OP_W-1:0] OP_LUI   = 6'd1;
  localparam logic [OP_W-1:0] OP_AUIPC = 6'd2;
  localparam logic [OP_W-1:0] OP_JAL   = 6'd3;
  localparam logic [OP_W-1:0] OP_JALR  = 6'd4;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'd5;
  localparam logic [OP_W-1:0] OP_BNE   = 6'd6;
  localparam logic [OP_W-1:0] OP_BLT   = 6'd7;
  localparam logic [OP_W-1:0] OP_BGE   = 6'd8;
  localparam logic [OP_W-1:0] OP_BLTU  = 6'd9;
  localparam logic [OP_W-1:0] OP_BGEU  = 6'd10;
  localparam logic [OP_W-1:0] OP_LB    = 6'd11;
  localparam logic [OP_W-1:0] OP_LH    = 6'd12;
  localparam logic [OP_W-1:0] OP_LW    = 6'd13;
  localparam logic [OP_W-1:0] OP_LBU   = 6'd14;
  localparam logic [OP_W-1:0] OP_LHU   = 6'd15;
  localparam logic [OP_W-1:0] OP_SB    = 6'd16;
  localparam logic [OP_W-1:0] OP_SH    = 6'd17;
  localparam logic [OP_W-1:0] OP_SW    = 6'd18;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'd19;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'd20;
  localparam logic [OP_W-1:0] OP_SLTIU = 6'd21;
  localparam logic [OP_W-1:0] OP_XORI  = 6'd22;
  localparam logic [OP_W-1:0] OP_ORI   = 6'd23;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'd24;
  localparam logic [OP_W-1:0] OP_SLLI  = 6'd25;
  localparam logic [OP_W-1:0] OP_SRLI  = 6'd26;
  localparam logic [OP_W-1:0] OP_SRAI  = 6'd27;
  localparam logic [OP_W-1:0] OP_ADD   = 6'd28;
  localparam logic [OP_W-1:0] OP_SUB   = 6'd29;
  localparam logic [OP_W-1:0] OP_SLL   = 6'd30;
  localparam logic [OP_W-1:0] OP_SLT   = 6'd31;
  localparam logic [OP_W-1:0] OP_SLTU  = 6'd32;
  localparam logic [OP_W-1:0] OP_XOR   = 6'd33;
  localparam logic [OP_W-1:0] OP_SRL   = 6'd34;
  localparam logic [OP_W-1:0] OP_SRA   = 6'd35;
  localparam logic [OP_W-1:0] OP_OR    = 6'd36;
  localparam logic [OP_W-1:0] OP_AND   = 6'd37;

endpackage

// File: rtl/dec_queue_core.sv
// dec_core: combinational RV32I (and RV32C when DEC_RVC_EN is defined) decoder.
// Latency: 0 (pure combinational). Backpressure: none, no state.
// Ports: ins_i/ic_i/pbr_i in; op/tp/rd/rs1/rs2/imm/pbr/ill out.
// Without DEC_RVC_EN every compressed instruction decodes as illegal.
// Illegal encodings always come out as op=0, tp=ALU, regs=0, imm=0, pbr=0.
module dec_core
  import dec_queue_pkg::*;
#(
  parameter int XLEN = DAT_W
) (
  input  logic [XLEN-1:0]    ins_i,
  input  logic               ic_i,
  input  logic               pbr_i,
  output logic [OP_W-1:0]    op_o,
  output logic [1:0]         tp_o,
  output logic [REG_BIT-1:0] rd_o,
  output logic [REG_BIT-1:0] rs1_o,
  output logic [REG_BIT-1:0] rs2_o,
  output logic [XLEN-1:0]    imm_o,
  output logic               pbr_o,
  output logic               ill_o
);

  logic [31:0] w;
  assign w = ins_i[31:0];

  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  assign imm_i = XLEN'($signed(w[31:20]));
  assign imm_s = XLEN'($signed({w[31:25], w[11:7]}));
  assign imm_b = XLEN'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({w[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
  assign shamt = XLEN'(w[24:20]);

`ifdef DEC_RVC_EN
  logic [15:0] c;
  logic [REG_BIT-1:0] crs1p, crs2p, crd, crs2;
  logic [XLEN-1:0] c_ci, c_j, c_b, c_16sp, c_lui, c_4spn, c_lw, c_lwsp, c_swsp;
  assign c      = ins_i[15:0];
  // 3-bit register fields address x8..x15
  assign crs1p  = {2'b01, c[9:7]};
  assign crs2p  = {2'b01, c[4:2]};
  assign crd    = c[11:7];
  assign crs2   = c[6:2];
  assign c_ci   = XLEN'($signed({c[12], c[6:2]}));
  assign c_j    = XLEN'($signed({c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0}));
  assign c_b    = XLEN'($signed({c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0}));
  assign c_16sp = XLEN'($signed({c[12], c[4:3], c[5], c[2], c[6], 4'b0}));
  assign c_lui  = XLEN'($signed({c[12], c[6:2], 12'b0}));
  assign c_4spn = XLEN'({c[10:7], c[12:11], c[5], c[6], 2'b0});
  assign c_lw   = XLEN'({c[5], c[12:10], c[6], 2'b0});
  assign c_lwsp = XLEN'({c[3:2], c[12], c[6:4], 2'b0});
  assign c_swsp = XLEN'({c[8:7], c[12:9], 2'b0});
`endif

  logic kill_pbr;

  always_comb begin
    op_o     = OP_NOP;
    tp_o     = TP_ALU;
    rd_o     = '0;
    rs1_o    = '0;
    rs2_o    = '0;
    imm_o    = '0;
    ill_o    = 1'b1;
    kill_pbr = 1'b0;
    pbr_o    = 1'b0;

    if (!ic_i) begin
      case (w[6:0])
        7'b0110111: begin op_o = OP_LUI;   rd_o = w[11:7]; imm_o = imm_u; ill_o = 1'b0; end
        7'b0010111: begin op_o = OP_AUIPC; rd_o = w[11:7]; imm_o = imm_u; ill_o = 1'b0; end
        7'b1101111: begin
          op_o = OP_JAL; tp_o = TP_BR; rd_o = w[11:7]; imm_o = imm_j; ill_o = 1'b0;
        end
        7'b1100111: begin
          op_o = OP_JALR; tp_o = TP_BR; rd_o = w[11:7]; rs1_o = w[19:15]; imm_o = imm_i;
          kill_pbr = 1'b1;
          ill_o = (w[14:12] != 3'b000);
        end
        7'b1100011: begin
          tp_o = TP_BR; rs1_o = w[19:15]; rs2_o = w[24:20]; imm_o = imm_b; ill_o = 1'b0;
          case (w[14:12])
            3'b000:  op_o = OP_BEQ;
            3'b001:  op_o = OP_BNE;
            3'b100:  op_o = OP_BLT;
            3'b101:  op_o = OP_BGE;
            3'b110:  op_o = OP_BLTU;
            3'b111:  op_o = OP_BGEU;
            default: ill_o = 1'b1;
          endcase
        end
        7'b0000011: begin
          tp_o = TP_LD; rd_o = w[11:7]; rs1_o = w[19:15]; imm_o = imm_i; ill_o = 1'b0;
          case (w[14:12])
            3'b000:  op_o = OP_LB;
            3'b001:  op_o = OP_LH;
            3'b010:  op_o = OP_LW;
            3'b100:  op_o = OP_LBU;
            3'b101:  op_o = OP_LHU;
            default: ill_o = 1'b1;
          endcase
        end
        7'b0100011: begin
          tp_o = TP_ST; rs1_o = w[19:15]; rs2_o = w[24:20]; imm_o = imm_s; ill_o = 1'b0;
          case (w[14:12])
            3'b000:  op_o = OP_SB;
            3'b001:  op_o = OP_SH;
            3'b010:  op_o = OP_SW;
            default: ill_o = 1'b1;
          endcase
        end
        7'b0010011: begin
          rd_o = w[11:7]; rs1_o = w[19:15]; imm_o = imm_i; ill_o = 1'b0;
          case (w[14:12])
            3'b000: op_o = OP_ADDI;
            3'b010: op_o = OP_SLTI;
            3'b011: op_o = OP_SLTIU;
            3'b100: op_o = OP_XORI;
            3'b110: op_o = OP_ORI;
            3'b111: op_o = OP_ANDI;
            3'b001: begin op_o = OP_SLLI; imm_o = shamt; end
            default: begin op_o = w[30] ? OP_SRAI : OP_SRLI; imm_o = shamt; end
          endcase
        end
        7'b0110011: begin
          rd_o = w[11:7]; rs1_o = w[19:15]; rs2_o = w[24:20]; ill_o = 1'b0;
          case (w[14:12])
            3'b000:  op_o = w[30] ? OP_SUB : OP_ADD;
            3'b001:  op_o = OP_SLL;
            3'b010:  op_o = OP_SLT;
            3'b011:  op_o = OP_SLTU;
            3'b100:  op_o = OP_XOR;
            3'b101:  op_o = w[30] ? OP_SRA : OP_SRL;
            3'b110:  op_o = OP_OR;
            default: op_o = OP_AND;
          endcase
        end
        default: ill_o = 1'b1;
      endcase
    end else begin
`ifdef DEC_RVC_EN
      ill_o = 1'b0;
      case ({c[1:0], c[15:13]})
        5'b00_000: begin  // c.addi4spn, zero immediate is reserved
          op_o = OP_ADDI; rd_o = crs2p; rs1_o = 5'd2; imm_o = c_4spn;
          ill_o = (c_4spn == '0);
        end
        5'b00_010: begin op_o = OP_LW; tp_o = TP_LD; rd_o = crs2p; rs1_o = crs1p; imm_o = c_lw; end
        5'b00_110: begin op_o = OP_SW; tp_o = TP_ST; rs1_o = crs1p; rs2_o = crs2p; imm_o = c_lw; end
        5'b01_000: begin op_o = OP_ADDI; rd_o = crd; rs1_o = crd; imm_o = c_ci; end
        5'b01_001: begin op_o = OP_JAL; tp_o = TP_BR; rd_o = 5'd1; imm_o = c_j; end
        5'b01_010: begin op_o = OP_ADDI; rd_o = crd; imm_o = c_ci; end
        5'b01_011: begin
          if (crd == 5'd2) begin
            op_o = OP_ADDI; rd_o = crd; rs1_o = crd; imm_o = c_16sp;
          end else begin
            op_o = OP_LUI; rd_o = crd; imm_o = c_lui;
          end
          ill_o = ({c[12], c[6:2]} == 6'd0);
        end
        5'b01_100: begin
          rd_o = crs1p; rs1_o = crs1p;
          case (c[11:10])
            2'b00: begin op_o = OP_SRLI; imm_o = XLEN'(c[6:2]); ill_o = c[12]; end
            2'b01: begin op_o = OP_SRAI; imm_o = XLEN'(c[6:2]); ill_o = c[12]; end
            2'b10: begin op_o = OP_ANDI; imm_o = c_ci; end
            default: begin
              rs2_o = crs2p;
              ill_o = c[12];
              case (c[6:5])
                2'b00:   op_o = OP_SUB;
                2'b01:   op_o = OP_XOR;
                2'b10:   op_o = OP_OR;
                default: op_o = OP_AND;
              endcase
            end
          endcase
        end
        5'b01_101: begin op_o = OP_JAL; tp_o = TP_BR; imm_o = c_j; end
        5'b01_110: begin op_o = OP_BEQ; tp_o = TP_BR; rs1_o = crs1p; imm_o = c_b; end
        5'b01_111: begin op_o = OP_BNE; tp_o = TP_BR; rs1_o = crs1p; imm_o = c_b; end
        5'b10_000: begin
          op_o = OP_SLLI; rd_o = crd; rs1_o = crd; imm_o = XLEN'(c[6:2]); ill_o = c[12];
        end
        5'b10_010: begin
          op_o = OP_LW; tp_o = TP_LD; rd_o = crd; rs1_o = 5'd2; imm_o = c_lwsp;
          ill_o = (crd == 5'd0);
        end
        5'b10_100: begin
          if (crs2 != 5'd0) begin  // c.mv / c.add
            op_o = OP_ADD; rd_o = crd; rs1_o = c[12] ? crd : 5'd0; rs2_o = crs2;
          end else begin           // c.jr / c.jalr; c.ebreak is unsupported
            op_o = OP_JALR; tp_o = TP_BR; rd_o = {4'b0, c[12]}; rs1_o = crd;
            kill_pbr = 1'b1;
            ill_o = (crd == 5'd0);
          end
        end
        5'b10_110: begin op_o = OP_SW; tp_o = TP_ST; rs1_o = 5'd2; rs2_o = crs2; imm_o = c_swsp; end
        default: ill_o = 1'b1;  // quadrant 11 and reserved funct3
      endcase
`endif
    end

    // Normalise every illegal path to a single clean payload.
    if (ill_o) begin
      op_o  = OP_NOP;
      tp_o  = TP_ALU;
      rd_o  = '0;
      rs1_o = '0;
      rs2_o = '0;
      imm_o = '0;
    end
    pbr_o = pbr_i && !ill_o && !kill_pbr;
  end

endmodule

// File: rtl/dec_queue.sv
// dec_queue: decode stage feeding a DEPTH-entry circular buffer of micro-ops.
// Latency: 1 cycle from push edge to is_valid_o. Backpressure: if_ready_o low when full, en=0, flush_i or reset.
// Ports: fetch side if_* (valid/ready), issue side is_* (valid/ready), en stall, flush_i, count_o.
// Optional macro DEC_RVC_EN enables RV32C decode; otherwise compressed pushes queue as illegal.
module dec_queue
  import dec_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADR_W = RAM_ADR_W,
  parameter int XLEN  = DAT_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               flush_i,
  input  logic               if_valid_i,
  output logic               if_ready_o,
  input  logic               if_ic_i,
  input  logic [XLEN-1:0]    if_ins_i,
  input  logic [ADR_W-1:0]   if_pc_i,
  input  logic               if_pbr_i,
  output logic               is_valid_o,
  input  logic               is_ready_i,
  output logic               is_ic_o,
  output logic [1:0]         is_tp_o,
  output logic [OP_W-1:0]    is_op_o,
  output logic [REG_BIT-1:0] is_rd_o,
  output logic [REG_BIT-1:0] is_rs1_o,
  output logic [REG_BIT-1:0] is_rs2_o,
  output logic [XLEN-1:0]    is_imm_o,
  output logic [ADR_W-1:0]   is_pc_o,
  output logic               is_pbr_o,
  output logic               is_ill_o,
  output logic [CNT_W-1:0]   count_o
);

  typedef struct packed {
    logic               ic;
    logic [1:0]         tp;
    logic [OP_W-1:0]    op;
    logic [REG_BIT-1:0] rd;
    logic [REG_BIT-1:0] rs1;
    logic [REG_BIT-1:0] rs2;
    logic [XLEN-1:0]    imm;
    logic [ADR_W-1:0]   pc;
    logic               pbr;
    logic               ill;
  } uop_t;

  uop_t dec_uop;
  uop_t mem_q [DEPTH];
  uop_t head;

  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  dec_core #(.XLEN(XLEN)) u_dec_core (
    .ins_i (if_ins_i),
    .ic_i  (if_ic_i),
    .pbr_i (if_pbr_i),
    .op_o  (dec_uop.op),
    .tp_o  (dec_uop.tp),
    .rd_o  (dec_uop.rd),
    .rs1_o (dec_uop.rs1),
    .rs2_o (dec_uop.rs2),
    .imm_o (dec_uop.imm),
    .pbr_o (dec_uop.pbr),
    .ill_o (dec_uop.ill)
  );
  assign dec_uop.ic = if_ic_i;
  assign dec_uop.pc = if_pc_i;

  // rst_n gates ready so fetch sees no acceptance while reset is held.
  assign if_ready_o = rst_n && (cnt_q < CNT_W'(DEPTH)) && en && !flush_i;
  assign is_valid_o = (cnt_q != '0);
  assign push       = if_valid_i && if_ready_o;
  assign pop        = is_valid_o && is_ready_i && en && !flush_i;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PTR_W'(1);
      if (pop)  rd_d = rd_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_W'(1);
        2'b01:   cnt_d = cnt_q - CNT_W'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage is reset so the payload outputs read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_q] <= dec_uop;
    end
  end

  assign head     = mem_q[rd_q];
  assign is_ic_o  = head.ic;
  assign is_tp_o  = head.tp;
  assign is_op_o  = head.op;
  assign is_rd_o  = head.rd;
  assign is_rs1_o = head.rs1;
  assign is_rs2_o = head.rs2;
  assign is_imm_o = head.imm;
  assign is_pc_o  = head.pc;
  assign is_pbr_o = head.pbr;
  assign is_ill_o = head.ill;
  assign count_o  = cnt_q;

endmodule

// File: tb/tb_dec_queue.sv
// Directed testbench for dec_queue: reset, decode of several formats,
// fill/backpressure ordering, flush, stall and illegal/jalr handling.
module tb_dec_queue;
  import dec_queue_pkg::*;

  logic        clk, rst_n, en, flush_i;
  logic        if_valid_i, if_ready_o, if_ic_i, if_pbr_i;
  logic [31:0] if_ins_i, if_pc_i;
  logic        is_valid_o, is_ready_i, is_ic_o, is_pbr_o, is_ill_o;
  logic [1:0]  is_tp_o;
  logic [5:0]  is_op_o;
  logic [4:0]  is_rd_o, is_rs1_o, is_rs2_o;
  logic [31:0] is_imm_o, is_pc_o;
  logic [2:0]  count_o;

  int checks = 0;
  int passed = 0;

  logic [31:0] seq [5];

  dec_queue #(.DEPTH(4), .ADR_W(32), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush_i(flush_i),
    .if_valid_i(if_valid_i), .if_ready_o(if_ready_o), .if_ic_i(if_ic_i),
    .if_ins_i(if_ins_i), .if_pc_i(if_pc_i), .if_pbr_i(if_pbr_i),
    .is_valid_o(is_valid_o), .is_ready_i(is_ready_i), .is_ic_o(is_ic_o),
    .is_tp_o(is_tp_o), .is_op_o(is_op_o), .is_rd_o(is_rd_o), .is_rs1_o(is_rs1_o),
    .is_rs2_o(is_rs2_o), .is_imm_o(is_imm_o), .is_pc_o(is_pc_o),
    .is_pbr_o(is_pbr_o), .is_ill_o(is_ill_o), .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] ins, input logic ic, input logic [31:0] pc, input logic pbr);
    if_ins_i = ins; if_ic_i = ic; if_pc_i = pc; if_pbr_i = pbr; if_valid_i = 1'b1;
    step();
    if_valid_i = 1'b0;
  endtask

  task automatic pop_one();
    is_ready_i = 1'b1;
    step();
    is_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b1; flush_i = 1'b0; if_valid_i = 1'b0; is_ready_i = 1'b0;
    if_ic_i = 1'b0; if_ins_i = '0; if_pc_i = '0; if_pbr_i = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (is_valid_o !== 1'b0) $display("FAIL rst_valid got %0d want 0", is_valid_o); else passed++;
    checks++; if (count_o !== 3'd0) $display("FAIL rst_count got %0d want 0", count_o); else passed++;
    checks++; if (if_ready_o !== 1'b0) $display("FAIL rst_ready got %0d want 0", if_ready_o); else passed++;
    checks++; if (is_op_o !== 6'd0 || is_imm_o !== 32'd0 || is_pc_o !== 32'd0)
      $display("FAIL rst_payload got op=%0d imm=%h pc=%h want 0", is_op_o, is_imm_o, is_pc_o); else passed++;
    #10 rst_n = 1'b1;
    #1;
    checks++; if (if_ready_o !== 1'b1) $display("FAIL rst_release_ready got %0d want 1", if_ready_o); else passed++;
  endtask

  task automatic test_addi();
    push_one(32'h00500093, 1'b0, 32'h100, 1'b0);
    checks++; if (is_valid_o !== 1'b1) $display("FAIL addi_valid got %0d want 1", is_valid_o); else passed++;
    checks++; if (count_o !== 3'd1) $display("FAIL addi_count got %0d want 1", count_o); else passed++;
    checks++; if (is_op_o !== OP_ADDI || is_tp_o !== 2'd3) $display("FAIL addi_op got op=%0d tp=%0d want op=%0d tp=3", is_op_o, is_tp_o, OP_ADDI); else passed++;
    checks++; if (is_rd_o !== 5'd1 || is_rs1_o !== 5'd0) $display("FAIL addi_regs got rd=%0d rs1=%0d want 1,0", is_rd_o, is_rs1_o); else passed++;
    checks++; if (is_imm_o !== 32'd5 || is_pc_o !== 32'h100 || is_ill_o !== 1'b0)
      $display("FAIL addi_imm_pc got imm=%h pc=%h ill=%0d want 5,100,0", is_imm_o, is_pc_o, is_ill_o); else passed++;
    pop_one();
    checks++; if (is_valid_o !== 1'b0 || count_o !== 3'd0) $display("FAIL addi_pop got valid=%0d count=%0d want 0,0", is_valid_o, count_o); else passed++;
  endtask

  task automatic test_formats();
    push_one(32'h402081B3, 1'b0, 32'h104, 1'b0);
    checks++; if (is_op_o !== OP_SUB || is_rd_o !== 5'd3 || is_rs1_o !== 5'd1 || is_rs2_o !== 5'd2 || is_imm_o !== 32'd0)
      $display("FAIL sub_decode got op=%0d rd=%0d rs1=%0d rs2=%0d imm=%h", is_op_o, is_rd_o, is_rs1_o, is_rs2_o, is_imm_o); else passed++;
    pop_one();
    push_one(32'h00208463, 1'b0, 32'h108, 1'b1);  // beq x1,x2,8 predicted taken
    checks++; if (is_op_o !== OP_BEQ || is_tp_o !== 2'd0 || is_imm_o !== 32'd8 || is_pbr_o !== 1'b1)
      $display("FAIL beq_decode got op=%0d tp=%0d imm=%h pbr=%0d", is_op_o, is_tp_o, is_imm_o, is_pbr_o); else passed++;
    pop_one();
    push_one(32'hFFC12283, 1'b0, 32'h10C, 1'b0);  // lw x5,-4(x2)
    checks++; if (is_op_o !== OP_LW || is_tp_o !== 2'd1 || is_rd_o !== 5'd5 || is_rs1_o !== 5'd2 || is_imm_o !== 32'hFFFFFFFC)
      $display("FAIL lw_decode got op=%0d tp=%0d rd=%0d rs1=%0d imm=%h", is_op_o, is_tp_o, is_rd_o, is_rs1_o, is_imm_o); else passed++;
    pop_one();
    push_one(32'h00312623, 1'b0, 32'h110, 1'b0);  // sw x3,12(x2)
    checks++; if (is_op_o !== OP_SW || is_tp_o !== 2'd2 || is_rs1_o !== 5'd2 || is_rs2_o !== 5'd3 || is_imm_o !== 32'd12)
      $display("FAIL sw_decode got op=%0d tp=%0d rs1=%0d rs2=%0d imm=%h", is_op_o, is_tp_o, is_rs1_o, is_rs2_o, is_imm_o); else passed++;
    pop_one();
  endtask

  task automatic test_rvc();
    push_one(32'h0000557D, 1'b1, 32'h120, 1'b0);
    checks++; if (is_ic_o !== 1'b1) $display("FAIL rvc_ic got %0d want 1", is_ic_o); else passed++;
`ifdef DEC_RVC_EN
    checks++; if (is_ill_o !== 1'b0 || is_op_o !== OP_ADDI || is_rd_o !== 5'd10 || is_rs1_o !== 5'd0 || is_imm_o !== 32'hFFFFFFFF)
      $display("FAIL rvc_cli got ill=%0d op=%0d rd=%0d rs1=%0d imm=%h", is_ill_o, is_op_o, is_rd_o, is_rs1_o, is_imm_o); else passed++;
`else
    checks++; if (is_ill_o !== 1'b1 || is_op_o !== 6'd0 || is_rd_o !== 5'd0 || is_imm_o !== 32'd0)
      $display("FAIL rvc_ill got ill=%0d op=%0d rd=%0d imm=%h want 1,0,0,0", is_ill_o, is_op_o, is_rd_o, is_imm_o); else passed++;
`endif
    pop_one();
  endtask

  task automatic test_full();
    seq[0] = 32'h00100093; seq[1] = 32'h00200113; seq[2] = 32'h00300193;
    seq[3] = 32'h00400213; seq[4] = 32'h00500293;
    is_ready_i = 1'b0; if_ic_i = 1'b0; if_pbr_i = 1'b0; if_valid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if_ins_i = seq[k]; if_pc_i = 32'h200 + 32'(k * 4);
      step();
    end
    checks++; if (count_o !== 3'd4 || if_ready_o !== 1'b0) $display("FAIL full_state got count=%0d ready=%0d want 4,0", count_o, if_ready_o); else passed++;
    if_ins_i = seq[4]; if_pc_i = 32'h210;
    step();
    checks++; if (count_o !== 3'd4 || is_rd_o !== 5'd1) $display("FAIL full_block got count=%0d rd=%0d want 4,1", count_o, is_rd_o); else passed++;
    is_ready_i = 1'b1;
    step();  // pop only: ready was low at this edge
    checks++; if (count_o !== 3'd3 || is_rd_o !== 5'd2 || if_ready_o !== 1'b1)
      $display("FAIL full_pop1 got count=%0d rd=%0d ready=%0d want 3,2,1", count_o, is_rd_o, if_ready_o); else passed++;
    step();  // push of 5th plus pop
    if_valid_i = 1'b0;
    checks++; if (count_o !== 3'd3 || is_rd_o !== 5'd3) $display("FAIL full_pushpop got count=%0d rd=%0d want 3,3", count_o, is_rd_o); else passed++;
    step();
    checks++; if (is_rd_o !== 5'd4 || is_pc_o !== 32'h20C) $display("FAIL full_order4 got rd=%0d pc=%h want 4,20c", is_rd_o, is_pc_o); else passed++;
    step();
    checks++; if (is_rd_o !== 5'd5 || is_pc_o !== 32'h210 || count_o !== 3'd1)
      $display("FAIL full_order5 got rd=%0d pc=%h count=%0d want 5,210,1", is_rd_o, is_pc_o, count_o); else passed++;
    step();
    is_ready_i = 1'b0;
    checks++; if (is_valid_o !== 1'b0 || count_o !== 3'd0) $display("FAIL full_drain got valid=%0d count=%0d want 0,0", is_valid_o, count_o); else passed++;
  endtask

  task automatic test_flush();
    push_one(32'h00100093, 1'b0, 32'h300, 1'b0);
    push_one(32'h00200113, 1'b0, 32'h304, 1'b0);
    push_one(32'h00300193, 1'b0, 32'h308, 1'b0);
    checks++; if (count_o !== 3'd3) $display("FAIL flush_pre got count=%0d want 3", count_o); else passed++;
    flush_i = 1'b1; if_valid_i = 1'b1; if_ins_i = 32'h00400213; is_ready_i = 1'b1;
    #1;
    checks++; if (if_ready_o !== 1'b0) $display("FAIL flush_ready got %0d want 0", if_ready_o); else passed++;
    step();
    flush_i = 1'b0; if_valid_i = 1'b0; is_ready_i = 1'b0;
    checks++; if (count_o !== 3'd0 || is_valid_o !== 1'b0) $display("FAIL flush_clear got count=%0d valid=%0d want 0,0", count_o, is_valid_o); else passed++;
    step();
    checks++; if (count_o !== 3'd0 || is_valid_o !== 1'b0) $display("FAIL flush_drop got count=%0d valid=%0d want 0,0", count_o, is_valid_o); else passed++;
  endtask

  task automatic test_stall();
    push_one(32'h00500093, 1'b0, 32'h400, 1'b0);
    en = 1'b0; is_ready_i = 1'b1; if_valid_i = 1'b1; if_ins_i = 32'h00200113;
    #1;
    checks++; if (if_ready_o !== 1'b0) $display("FAIL stall_ready got %0d want 0", if_ready_o); else passed++;
    step(); step();
    checks++; if (count_o !== 3'd1 || is_valid_o !== 1'b1 || is_pc_o !== 32'h400)
      $display("FAIL stall_hold got count=%0d valid=%0d pc=%h want 1,1,400", count_o, is_valid_o, is_pc_o); else passed++;
    en = 1'b1; if_valid_i = 1'b0;
    step();
    is_ready_i = 1'b0;
    checks++; if (count_o !== 3'd0) $display("FAIL stall_resume got count=%0d want 0", count_o); else passed++;
  endtask

  task automatic test_illegal_jalr();
    push_one(32'hFFFFFFFF, 1'b0, 32'h500, 1'b1);
    checks++; if (is_ill_o !== 1'b1 || is_op_o !== 6'd0 || is_tp_o !== 2'd3 || is_imm_o !== 32'd0 || is_pbr_o !== 1'b0 || is_rd_o !== 5'd0)
      $display("FAIL ill_entry got ill=%0d op=%0d tp=%0d imm=%h pbr=%0d rd=%0d", is_ill_o, is_op_o, is_tp_o, is_imm_o, is_pbr_o, is_rd_o); else passed++;
    pop_one();
    push_one(32'h00008067, 1'b0, 32'h504, 1'b1);
    checks++; if (is_op_o !== OP_JALR || is_tp_o !== 2'd0 || is_pbr_o !== 1'b0 || is_rs1_o !== 5'd1 || is_ill_o !== 1'b0)
      $display("FAIL jalr_entry got op=%0d tp=%0d pbr=%0d rs1=%0d ill=%0d", is_op_o, is_tp_o, is_pbr_o, is_rs1_o, is_ill_o); else passed++;
    pop_one();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_formats();
    test_rvc();
    test_full();
    test_flush();
    test_stall();
    test_illegal_jalr();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
